// File: rtl/elevator_car_controller.sv
// Per-car motion and door sequencer. One instance per car. It takes the hall calls the dispatcher
// assigned to this car plus the in-car buttons, and drives the car's floor/direction back to the
// dispatcher together with the door control and a one-cycle served-call mask.
module elevator_car_controller #(
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] assignedButton,
    input  logic [6:0]  carButton,
    output logic [2:0]  currentFloor,
    output logic [1:0]  direction,
    output logic        doorOpen,
    output logic [13:0] servedButton,
    output logic [6:0]  carCall
);

    localparam int unsigned MoveW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int unsigned DoorW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MoveW-1:0] MoveLast = MoveW'(MOVE_CYCLES - 1);
    localparam logic [DoorW-1:0] DoorLast = DoorW'(DOOR_CYCLES - 1);

    localparam logic [1:0] DirStop = 2'b00;
    localparam logic [1:0] DirUp   = 2'b10;
    localparam logic [1:0] DirDown = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StMoveUp,
        StMoveDown,
        StDoor
    } state_e;

    state_e            stateQ, stateD;
    logic [2:0]        floorQ, floorD;
    logic [1:0]        dirQ, dirD;
    logic [MoveW-1:0]  moveCntQ, moveCntD;
    logic [DoorW-1:0]  doorCntQ, doorCntD;
    logic [6:0]        carCallQ, carCallD;
    // Set for the one cycle right after a floor step, when the stop decision is taken.
    logic              arrivedQ, arrivedD;

    logic [6:0]        effCall, hallUp, hallDown, reqVec;
    logic [6:0]        hereMask, aboveMask, belowMask;
    logic              reqHere, reqAbove, reqBelow, reqAhead, reqBehind;
    logic              callHere, upHere, downHere, hallHere;
    logic              inDoor, serveUp, serveDown, service;
    logic [DoorW-1:0]  doorEff;

    // Request predicates on the current-cycle view (latched calls plus this cycle's buttons).
    always_comb begin
        hallUp    = '0;
        hallDown  = '0;
        aboveMask = '0;
        belowMask = '0;
        for (int i = 0; i < 7; i++) begin
            hallUp[i]    = assignedButton[2*i];
            hallDown[i]  = assignedButton[2*i+1];
            aboveMask[i] = (3'(i + 1) > floorQ);
            belowMask[i] = (3'(i + 1) < floorQ);
        end
        effCall  = carCallQ | carButton;
        reqVec   = effCall | hallUp | hallDown;
        hereMask = 7'd1 << (floorQ - 3'd1);
        reqHere  = |(reqVec & hereMask);
        reqAbove = |(reqVec & aboveMask);
        reqBelow = |(reqVec & belowMask);
        callHere = |(effCall & hereMask);
        upHere   = |(hallUp & hereMask);
        downHere = |(hallDown & hereMask);
        hallHere = upHere | downHere;
        unique case (dirQ)
            DirUp:   begin reqAhead = reqAbove; reqBehind = reqBelow; end
            DirDown: begin reqAhead = reqBelow; reqBehind = reqAbove; end
            default: begin reqAhead = 1'b0;     reqBehind = 1'b0;     end
        endcase
    end

    // Served mask: only the direction-matching hall bit, unless the car is about to turn or stop.
    always_comb begin
        inDoor       = (stateQ == StDoor);
        serveUp      = inDoor && upHere && ((dirQ != DirDown) || !reqAhead);
        serveDown    = inDoor && downHere && ((dirQ != DirUp) || !reqAhead);
        service      = inDoor && (callHere || serveUp || serveDown);
        doorEff      = service ? '0 : doorCntQ;
        servedButton = '0;
        for (int i = 0; i < 7; i++) begin
            servedButton[2*i]   = serveUp && hereMask[i];
            servedButton[2*i+1] = serveDown && hereMask[i];
        end
    end

    // Next-state logic for motion, door timing and the car-call latch.
    always_comb begin
        stateD   = stateQ;
        floorD   = floorQ;
        dirD     = dirQ;
        moveCntD = moveCntQ;
        doorCntD = doorCntQ;
        arrivedD = 1'b0;
        carCallD = carCallQ | carButton;

        unique case (stateQ)
            StIdle: begin
                dirD     = DirStop;
                moveCntD = '0;
                doorCntD = '0;
                if (reqHere) begin
                    stateD = StDoor;
                end else if (reqAbove) begin
                    stateD = StMoveUp;
                    dirD   = DirUp;
                end else if (reqBelow) begin
                    stateD = StMoveDown;
                    dirD   = DirDown;
                end
            end

            StMoveUp: begin
                if (arrivedQ && (callHere || upHere || (!reqAbove && hallHere) ||
                                 (floorQ == 3'd7))) begin
                    stateD   = StDoor;
                    doorCntD = '0;
                    moveCntD = '0;
                end else if (arrivedQ && !reqAbove) begin
                    // Calls were withdrawn while travelling.
                    stateD   = StIdle;
                    dirD     = DirStop;
                    moveCntD = '0;
                end else if (moveCntQ == MoveLast) begin
                    moveCntD = '0;
                    arrivedD = 1'b1;
                    if (floorQ < 3'd7) floorD = floorQ + 3'd1;
                end else begin
                    moveCntD = moveCntQ + 1'b1;
                end
            end

            StMoveDown: begin
                if (arrivedQ && (callHere || downHere || (!reqBelow && hallHere) ||
                                 (floorQ == 3'd1))) begin
                    stateD   = StDoor;
                    doorCntD = '0;
                    moveCntD = '0;
                end else if (arrivedQ && !reqBelow) begin
                    stateD   = StIdle;
                    dirD     = DirStop;
                    moveCntD = '0;
                end else if (moveCntQ == MoveLast) begin
                    moveCntD = '0;
                    arrivedD = 1'b1;
                    if (floorQ > 3'd1) floorD = floorQ - 3'd1;
                end else begin
                    moveCntD = moveCntQ + 1'b1;
                end
            end

            StDoor: begin
                // Clearing here beats a same-cycle press of the button at this floor.
                carCallD = (carCallQ | carButton) & ~hereMask;
                if (doorEff == DoorLast) begin
                    doorCntD = '0;
                    moveCntD = '0;
                    if (reqAhead) begin
                        stateD = (dirQ == DirUp) ? StMoveUp : StMoveDown;
                    end else if (reqBehind) begin
                        stateD = (dirQ == DirUp) ? StMoveDown : StMoveUp;
                        dirD   = (dirQ == DirUp) ? DirDown : DirUp;
                    end else begin
                        stateD = StIdle;
                        dirD   = DirStop;
                    end
                end else begin
                    doorCntD = doorEff + 1'b1;
                end
            end

            default: begin
                stateD = StIdle;
                dirD   = DirStop;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            floorQ   <= 3'd1;
            dirQ     <= DirStop;
            moveCntQ <= '0;
            doorCntQ <= '0;
            carCallQ <= '0;
            arrivedQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            floorQ   <= floorD;
            dirQ     <= dirD;
            moveCntQ <= moveCntD;
            doorCntQ <= doorCntD;
            carCallQ <= carCallD;
            arrivedQ <= arrivedD;
        end
    end

    assign currentFloor = floorQ;
    assign direction    = dirQ;
    assign doorOpen     = (stateQ == StDoor);
    assign carCall      = carCallQ;

endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
- Per-car motion and door sequencer. Sits directly downstream of the hall-call dispatcher; one instance per car (two in the design).
- Consumes the car's assigned hall-call vector and its in-car floor buttons.
- Produces the car's currentFloor and direction, which feed back to the dispatcher, plus the door control and a served-call pulse mask.
- Floors are 1..7, encoded in 3 bits. Floor value 0 never occurs.

Parameters:
MOVE_CYCLES, 4, clock cycles to travel one floor (≥1)
DOOR_CYCLES, 3, clock cycles the door stays open per stop (≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
assignedButton  input  14  hall calls owned by this car; floor f uses bit 2f-2 = UP call, bit 2f-1 = DOWN call
carButton  input  7  in-car floor buttons, bit f-1 = floor f; level or pulse, latched internally
currentFloor  output  3  floor the car is at or last passed (1..7)
direction  output  2  STOP=2'b00, UP=2'b10, DOWN=2'b01; 2'b11 never driven
doorOpen  output  1  high while the door is open
servedButton  output  14  one-cycle pulse, hall-call bits satisfied this cycle (same layout as assignedButton)
carCall  output  7  latched pending in-car calls

Behaviour:
- Reset values (next edge with reset=1, regardless of state, including mid-move or door open): currentFloor=1, direction=STOP, doorOpen=0, servedButton=0, carCall=0, state=IDLE, counters=0.
- carCall latch: carCall |= carButton every cycle. Bits are cleared only by a door-open service at that floor. If set and clear hit the same floor in the same cycle, the clear wins.
- Request predicates, all on the current-cycle view:
  - reqHere: carCall, or either hall bit, at currentFloor.
  - reqAbove: any carCall or hall bit at a floor > currentFloor.
  - reqBelow: any carCall or hall bit at a floor < currentFloor.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE (direction=STOP):
  - reqHere → DOOR.
  - else reqAbove → MOVE_UP, direction=UP.
  - else reqBelow → MOVE_DOWN, direction=DOWN.
  - Priority is reqHere > reqAbove > reqBelow.
- MOVE_UP / MOVE_DOWN:
  - Move counter counts 0..MOVE_CYCLES-1. On the cycle it hits MOVE_CYCLES-1, currentFloor changes by ±1 and the counter clears.
  - Arrival check uses the new floor, on the following cycle. Stop (→DOOR) if any of:
    - carCall at the floor;
    - the hall bit matching direction;
    - no further requests ahead and any hall bit at the floor.
  - Otherwise continue.
  - Floor 7 in MOVE_UP and floor 1 in MOVE_DOWN always stop. currentFloor never leaves 1..7.
  - If requests vanish mid-travel (dispatcher reassigns a call), finish the current floor step, then go to IDLE with direction=STOP.
- DOOR entry cycle:
  - doorOpen=1 and door counter=0.
  - Clear carCall at the floor.
  - servedButton pulses the hall bit matching direction. Pulse both hall bits if direction=STOP or there are no requests ahead.
  - direction is held during DOOR.
- DOOR hold:
  - doorOpen stays high for exactly DOOR_CYCLES cycles.
  - A new matching request at currentFloor during DOOR restarts the door counter and issues a new served pulse/clear.
- DOOR exit:
  - requests ahead in direction → continue in that direction.
  - else requests behind → reverse direction.
  - else IDLE with direction=STOP.
  - doorOpen=0 on the exit cycle.
- Door and motion are mutually exclusive: currentFloor never changes while doorOpen=1.
- servedButton is zero except on service cycles and is never asserted for a bit not set in assignedButton that cycle.

Test Plan:
- Reset then idle: reset 2 cycles, no requests → currentFloor=1, direction=00, doorOpen=0, servedButton=0 held 20 cycles.
- Single car call: carButton=7'b0001000 (floor 4), MOVE_CYCLES=4 → direction=10, floor 2/3/4 at +4/+8/+12 cycles. doorOpen high 3 cycles, carCall[3] cleared, then direction=00.
- Pass-through vs stop:
  - Car moving up from 1 to 6. assignedButton bit 5 (floor 3 DOWN) set → car does not stop at 3.
  - bit 4 (floor 3 UP) set → stops at 3 with servedButton=14'h0010.
- Reversal: at floor 5 with carCall floor 7 and hall DOWN floor 2 → serves 7, door cycle, direction becomes 01, serves 2.
- Call at current floor while idle: floor 1, assignedButton bit 0 set → DOOR on next cycle, servedButton=14'h0001. Re-press during door → door extended to 3 cycles from re-press.
- Reset mid-move: assert reset while moving between floors 3→4 → next cycle floor=1, direction=00, carCall=0, doorOpen=0.
